// File: rtl/muldiv_pkg.sv
// Shared types for the M-extension issue/writeback controller.
// Holds funct3 codes, the controller FSM states and the in-flight slot bundle.
package muldiv_pkg;

  localparam int MD_RA_W = 5;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } muldiv_state_e;

  typedef struct packed {
    logic               v;
    logic [MD_RA_W-1:0] rd;
  } md_slot_t;

endpackage

// File: rtl/muldiv_issue_ctrl_md_rd_tracker.sv
// Shift pipe of in-flight destination registers, one slot per unit stage.
// Flags RAW hazards against every slot, including the completing one.
module md_rd_tracker
  import muldiv_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int RA_W    = MD_RA_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue,
  input  logic [RA_W-1:0] rd,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  output md_slot_t        done,
  output logic            busy,
  output logic            hazard,
  output logic            empty_next
);

  md_slot_t [LATENCY-1:0] slots;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slots <= '0;
    end else begin
      slots[0] <= '{v: issue, rd: rd};
      for (int i = 1; i < LATENCY; i++) begin
        slots[i] <= slots[i-1];
      end
    end
  end

  always_comb begin
    busy   = 1'b0;
    hazard = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | slots[i].v;
      if (slots[i].v && (slots[i].rd != '0) &&
          ((slots[i].rd == rs1) || (slots[i].rd == rs2))) begin
        hazard = 1'b1;
      end
    end
  end

  // The completing slot leaves next cycle, so only younger slots matter.
  always_comb begin
    empty_next = ~issue;
    for (int i = 0; i < LATENCY - 1; i++) begin
      empty_next = empty_next & ~slots[i].v;
    end
  end

  assign done = slots[LATENCY-1];

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue and writeback control between EX decode and the pipelined muldiv unit.
// Muldiv completions always win the register write port over the ALU.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2,
  parameter int RA_W    = MD_RA_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [RA_W-1:0] req_rd_i,
  input  logic [XLEN-1:0] req_in1_i,
  input  logic [XLEN-1:0] req_in2_i,
  input  logic            kill_i,
  input  logic            drain_i,
  output logic            md_en_o,
  output logic [2:0]      md_funct3_o,
  output logic [XLEN-1:0] md_in1_o,
  output logic [XLEN-1:0] md_in2_o,
  input  logic [XLEN-1:0] md_result_i,
  input  logic [RA_W-1:0] rs1_i,
  input  logic [RA_W-1:0] rs2_i,
  output logic            hazard_o,
  input  logic            alu_wb_valid_i,
  output logic            alu_stall_o,
  output logic            wb_valid_o,
  output logic [RA_W-1:0] wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            busy_o
);

  muldiv_state_e state_q, state_d;
  md_slot_t      done;
  logic          issue;
  logic          empty_next;

  assign req_ready_o = (state_q != DRAIN) & ~drain_i;
  assign issue       = req_valid_i & req_ready_o & ~kill_i;

  assign md_en_o     = issue;
  assign md_funct3_o = req_funct3_i;
  assign md_in1_o    = req_in1_i;
  assign md_in2_o    = req_in2_i;

  md_rd_tracker #(
    .LATENCY (LATENCY),
    .RA_W    (RA_W)
  ) u_tracker (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .issue      (issue),
    .rd         (req_rd_i),
    .rs1        (rs1_i),
    .rs2        (rs2_i),
    .done       (done),
    .busy       (busy_o),
    .hazard     (hazard_o),
    .empty_next (empty_next)
  );

  assign wb_valid_o  = done.v & (done.rd != '0);
  assign wb_rd_o     = done.rd;
  assign wb_data_o   = md_result_i;
  assign alu_stall_o = wb_valid_o & alu_wb_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue) state_d = RUN;
      end
      RUN: begin
        if (drain_i)         state_d = DRAIN;
        else if (empty_next) state_d = IDLE;
      end
      DRAIN: begin
        if (empty_next && !drain_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Issue/writeback controller sitting between the EX-stage decode and the pipelined M-extension unit (multiplier + divider, fixed latency LATENCY, one op accepted per cycle).
- Accepts requests with valid/ready and tracks destination registers of in-flight ops in a shift pipeline.
- Raises RAW hazards against in-flight rd, arbitrates the single register-file write port against the ALU (muldiv wins), and supports drain for fences/CSR/interrupt entry.

Parameters:
- XLEN, 32, datapath width
- LATENCY, 2, cycles from md_en_o issue to md_result_i valid (equals unit NUM_STAGE); legal range 1..8
- RA_W, 5, register address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- req_valid_i  in  1  decoded muldiv op present
- req_ready_o  out  1  op accepted this cycle
- req_funct3_i  in  3  M-extension funct3
- req_rd_i  in  RA_W  destination register
- req_in1_i  in  XLEN  operand 1
- req_in2_i  in  XLEN  operand 2
- kill_i  in  1  current request squashed (branch flush); blocks its issue only
- drain_i  in  1  stop accepting and empty the pipe
- md_en_o  out  1  issue strobe to unit
- md_funct3_o  out  3  to unit
- md_in1_o  out  XLEN  to unit
- md_in2_o  out  XLEN  to unit
- md_result_i  in  XLEN  unit result, valid LATENCY cycles after md_en_o
- rs1_i  in  RA_W  consumer source 1 (decode)
- rs2_i  in  RA_W  consumer source 2
- hazard_o  out  1  rs1/rs2 matches a pending rd
- alu_wb_valid_i  in  1  ALU wants the write port this cycle
- alu_stall_o  out  1  ALU loses arbitration; hold ALU result
- wb_valid_o  out  1  write port enable
- wb_rd_o  out  RA_W  write address
- wb_data_o  out  XLEN  write data (= md_result_i)
- busy_o  out  1  any op in flight

Behaviour:
- Reset rst_ni: asynchronous, active-low. clk_i rising edge. All slot valids 0, state IDLE. Outputs at reset: req_ready_o=1, md_en_o=0, wb_valid_o=0, hazard_o=0, alu_stall_o=0, busy_o=0, wb_rd_o=0.
- Tracking pipe: LATENCY slots {v, rd}. Slot0 loads {issue, req_rd_i}; slot i loads slot i-1 each cycle; slot LATENCY-1 is "completing".
- Issue: issue = req_valid_i & req_ready_o & ~kill_i. md_en_o = issue. md_* operand outputs are combinational pass-through of req_*.
- Ready: req_ready_o = (state != DRAIN) & ~drain_i. Ready does not depend on req_valid_i.
- Writeback: wb_valid_o = completing.v & (completing.rd != 0). wb_rd_o = completing.rd. wb_data_o = md_result_i.
- rd=0 ops: issued and tracked (busy_o counts them), but never write back and never hazard.
- Arbitration: alu_stall_o = wb_valid_o & alu_wb_valid_i. Muldiv always wins; the ALU retries next cycle.
- Hazard: hazard_o = OR over slots 0..LATENCY-1 of (v & rd != 0 & (rd == rs1_i | rd == rs2_i)).
  - The completing slot counts as a hazard; there is no WB bypass inside this block.
  - rs = 0 never hazards.
- FSM:
  - IDLE: no slot valid. issue -> RUN. drain_i -> stay IDLE (already empty).
  - RUN: drain_i -> DRAIN. All slots empty next cycle and no issue -> IDLE.
  - DRAIN: no issue accepted. Slots empty (next-cycle view) and drain_i=0 -> IDLE. Slots empty and drain_i still 1 -> stay DRAIN.
- busy_o = OR of slot valids. busy_o reflects registered slots, not same-cycle issue.
- kill_i with req_valid_i: no issue, no slot, ready unaffected.
- kill_i never affects in-flight ops: they are older than the flushing branch and always complete.
- Back-to-back issue every cycle is legal. Each op completes exactly LATENCY cycles later, in order.
- Reset mid-operation: all in-flight ops are dropped with no writeback; the unit's internal state is don't-care because no slot remains valid.

Decomposition:
- Shared package muldiv_pkg: FUNCT3_* constants (MUL..REMU), state enum muldiv_state_e {IDLE, RUN, DRAIN}, slot struct md_slot_t {v, rd}.
- One natural sub-module: md_rd_tracker (the LATENCY-slot shift pipe plus hazard compare, outputs completing slot and busy).

Test Plan:
- LATENCY=2, issue MUL rd=5 at cycle 0 -> md_en_o=1 at c0, hazard_o=1 for rs1=5 at c1–c2, wb_valid_o=1 with wb_rd_o=5 and wb_data_o=md_result_i at c2, busy_o=0 at c3.
- Issue every cycle with rd=1,2,3,4 -> wb_rd_o=1,2,3,4 on consecutive cycles starting 2 cycles after the first issue; req_ready_o stays 1.
- alu_wb_valid_i=1 held throughout while a MUL rd=7 completes -> alu_stall_o=1 only in the completion cycle; wb_rd_o=7.
- Issue DIV rd=0 -> busy_o=1 for 2 cycles, wb_valid_o never 1, hazard_o=0 for rs1=0.
- Issue rd=9, then next cycle req_valid_i=1 with kill_i=1 and rd=10 -> md_en_o=0 for the second request; rd=9 still writes back, rd=10 never appears.
- Two ops in flight, assert drain_i -> req_ready_o=0 immediately; both ops write back; FSM reaches IDLE after deassert once empty; async reset mid-flight -> wb_valid_o=0 and busy_o=0 immediately.
